// File: rtl/code_loader.sv
// Program-load initiator: parses framed byte stream (HEADER, N, N x 4-byte records, CSUM)
// and writes 24-bit code words, raising start only when the frame checksum verifies.
module code_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [7:0]  Code_address,
    output logic [23:0] Code_Data,
    output logic        Write_Code,
    output logic        start,
    output logic        load_error,
    output logic [7:0]  records_written
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_ADDR, S_DH, S_DM, S_DL, S_WRITE, S_CSUM, S_RUN, S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic                byte_ready_q, byte_ready_d;
    logic [7:0]          code_address_q, code_address_d;
    logic [23:0]         code_data_q, code_data_d;
    logic                write_code_q, write_code_d;
    logic                start_q, start_d;
    logic                load_error_q, load_error_d;
    logic [7:0]          rec_q, rec_d;
    logic [7:0]          remain_q, remain_d;
    logic [7:0]          xor_q, xor_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          dh_q, dh_d;
    logic [7:0]          dm_q, dm_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    logic accept;
    logic in_frame;

    assign accept   = byte_valid && byte_ready_q;
    assign in_frame = state_q inside {S_COUNT, S_ADDR, S_DH, S_DM, S_DL, S_CSUM};

    assign byte_ready      = byte_ready_q;
    assign Code_address    = code_address_q;
    assign Code_Data       = code_data_q;
    assign Write_Code      = write_code_q;
    assign start           = start_q;
    assign load_error      = load_error_q;
    assign records_written = rec_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q        <= S_IDLE;
            byte_ready_q   <= 1'b0;
            code_address_q <= 8'h00;
            code_data_q    <= 24'h000000;
            write_code_q   <= 1'b0;
            start_q        <= 1'b0;
            load_error_q   <= 1'b0;
            rec_q          <= 8'h00;
            remain_q       <= 8'h00;
            xor_q          <= 8'h00;
            addr_q         <= 8'h00;
            dh_q           <= 8'h00;
            dm_q           <= 8'h00;
            idle_q         <= '0;
        end else begin
            state_q        <= state_d;
            byte_ready_q   <= byte_ready_d;
            code_address_q <= code_address_d;
            code_data_q    <= code_data_d;
            write_code_q   <= write_code_d;
            start_q        <= start_d;
            load_error_q   <= load_error_d;
            rec_q          <= rec_d;
            remain_q       <= remain_d;
            xor_q          <= xor_d;
            addr_q         <= addr_d;
            dh_q           <= dh_d;
            dm_q           <= dm_d;
            idle_q         <= idle_d;
        end
    end

    // Frame parser; the write strobe and its address/data are registered on the DL byte
    // so they are visible exactly during the WRITE cycle.
    always_comb begin
        state_d        = state_q;
        code_address_d = code_address_q;
        code_data_d    = code_data_q;
        write_code_d   = 1'b0;
        start_d        = start_q;
        load_error_d   = load_error_q;
        rec_d          = rec_q;
        remain_d       = remain_q;
        xor_d          = xor_q;
        addr_d         = addr_q;
        dh_d           = dh_q;
        dm_d           = dm_q;
        idle_d         = '0;

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (accept && byte_in == HEADER) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (accept) begin
                    remain_d     = byte_in;
                    xor_d        = byte_in;
                    rec_d        = 8'h00;
                    load_error_d = 1'b0;
                    start_d      = 1'b0;
                    state_d      = (byte_in == 8'h00) ? S_CSUM : S_ADDR;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = byte_in;
                    xor_d   = xor_q ^ byte_in;
                    state_d = S_DH;
                end
            end
            S_DH: begin
                if (accept) begin
                    dh_d    = byte_in;
                    xor_d   = xor_q ^ byte_in;
                    state_d = S_DM;
                end
            end
            S_DM: begin
                if (accept) begin
                    dm_d    = byte_in;
                    xor_d   = xor_q ^ byte_in;
                    state_d = S_DL;
                end
            end
            S_DL: begin
                if (accept) begin
                    code_address_d = addr_q;
                    code_data_d    = {dh_q, dm_q, byte_in};
                    write_code_d   = 1'b1;
                    rec_d          = rec_q + 8'd1;
                    xor_d          = xor_q ^ byte_in;
                    state_d        = S_WRITE;
                end
            end
            S_WRITE: begin
                remain_d = remain_q - 8'd1;
                state_d  = (remain_q == 8'd1) ? S_CSUM : S_ADDR;
            end
            S_CSUM: begin
                if (accept) begin
                    if (byte_in == xor_q) begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte idle watchdog inside a frame.
        if (TIMEOUT != 0 && in_frame && !accept) begin
            if (idle_q == IDLE_LAST) begin
                state_d      = S_ERROR;
                load_error_d = 1'b1;
                start_d      = 1'b0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    assign byte_ready_d = (state_d != S_WRITE);

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed frame table, hand-written corner
// sequences (reload, timeout, async reset) and random frames against a frame-level model.
module tb_code_loader;

    localparam int unsigned TO = 32;

    logic        clk;
    logic        clear;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  Code_address;
    logic [23:0] Code_Data;
    logic        Write_Code;
    logic        start;
    logic        load_error;
    logic [7:0]  records_written;

    code_loader #(.HEADER(8'hA5), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .clear           (clear),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .Code_address    (Code_address),
        .Code_Data       (Code_Data),
        .Write_Code      (Write_Code),
        .start           (start),
        .load_error      (load_error),
        .records_written (records_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] exp_wr[$];
    logic [31:0] wr_q[$];
    int          rdy_low = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int          nb;
        logic [95:0] b;
        int          nw;
        logic [63:0] w;
        logic        st;
        logic        er;
        logic [7:0]  rw;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write capture; the write strobe must coincide with byte_ready low.
    always @(negedge clk) begin
        if (Write_Code) begin
            wr_q.push_back({Code_address, Code_Data});
            chk("wr_ready_low", 32'(byte_ready), 32'(1'b0));
        end
        if (mon_en && !byte_ready) rdy_low++;
    end

    task automatic send_byte(input logic [7:0] b);
        int tries;
        tries = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0h actual=ready_low required=accepted", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_tx(input int gap_max, input bit long_en);
        int g;
        wr_q.delete();
        rdy_low = 0;
        mon_en  = 1'b1;
        foreach (tx_q[i]) begin
            if (i > 0) begin
                g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
                // Longest gap that must not trip the idle watchdog.
                if (long_en && $urandom_range(0, 19) == 0) g = TO - 1;
                repeat (g) @(negedge clk);
            end
            if (i == tx_q.size() - 1) chk("start_pre_csum", 32'(start), 32'(1'b0));
            send_byte(tx_q[i]);
        end
        mon_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic st, input logic er, input logic [7:0] rw);
        int n;
        chk({tag, ".nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.wr%0d", tag, i), wr_q[i], exp_wr[i]);
        chk({tag, ".rdy_low"}, 32'(rdy_low), 32'(exp_wr.size()));
        chk({tag, ".start"}, 32'(start), 32'(st));
        chk({tag, ".load_error"}, 32'(load_error), 32'(er));
        chk({tag, ".records"}, 32'(records_written), 32'(rw));
        if (exp_wr.size() > 0)
            chk({tag, ".hold"}, {Code_address, Code_Data}, exp_wr[exp_wr.size() - 1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a;
        logic [7:0]  prev_a;
        logic [23:0] d;
        logic [7:0]  x;
        logic [7:0]  n;
        logic [7:0]  s;
        bit          ok;

        // Byte streams are right-aligned, first byte most significant; writes list first at bits [31:0].
        vecs[0] = '{7,  96'hA5_01_00_07_CC_C9_03, 1, 64'h00000000_0007CCC9, 1'b1, 1'b0, 8'd1, 1};
        vecs[1] = '{11, 96'hA5_02_00_07_CC_C9_01_08_00_07_0E, 2, 64'h01080007_0007CCC9, 1'b1, 1'b0, 8'd2, 0};
        vecs[2] = '{7,  96'hA5_01_00_07_CC_C9_04, 1, 64'h00000000_0007CCC9, 1'b0, 1'b1, 8'd1, 0};
        vecs[3] = '{4,  96'h07_A5_00_00, 0, 64'h0, 1'b1, 1'b0, 8'd0, 1};
        vecs[4] = '{11, 96'hA5_02_A5_11_22_33_A5_44_55_66_75, 2, 64'hA5445566_A5112233, 1'b1, 1'b0, 8'd2, 2};

        clear      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #3;
        chk("rst.ready", 32'(byte_ready), 32'(1'b0));
        chk("rst.addr", 32'(Code_address), 32'h0);
        chk("rst.data", 32'(Code_Data), 32'h0);
        chk("rst.wr", 32'(Write_Code), 32'(1'b0));
        chk("rst.start", 32'(start), 32'(1'b0));
        chk("rst.err", 32'(load_error), 32'(1'b0));
        chk("rst.records", 32'(records_written), 32'h0);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        #1;
        chk("rel.ready_before_clk", 32'(byte_ready), 32'(1'b0));
        @(negedge clk);
        chk("rel.ready_after_clk", 32'(byte_ready), 32'(1'b1));

        // Directed frame table.
        for (int i = 0; i < 5; i++) begin
            tx_q.delete();
            exp_wr.delete();
            for (int k = 0; k < vecs[i].nb; k++) tx_q.push_back(vecs[i].b[8*(vecs[i].nb-1-k) +: 8]);
            for (int k = 0; k < vecs[i].nw; k++) exp_wr.push_back(vecs[i].w[32*k +: 32]);
            run_tx(vecs[i].gap, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].st, vecs[i].er, vecs[i].rw);
        end

        // Reload while running: start stays high in COUNT, drops once N is taken.
        send_byte(8'hA5);
        chk("reload.start_in_count", 32'(start), 32'(1'b1));
        send_byte(8'h01);
        chk("reload.start_after_count", 32'(start), 32'(1'b0));
        chk("reload.records_cleared", 32'(records_written), 32'h0);
        tx_q   = '{8'h60, 8'hF0, 8'h08, 8'h20, 8'hB9};
        exp_wr = '{32'h60F00820};
        run_tx(0, 1'b0);
        check_frame("reload", 1'b1, 1'b0, 8'd1);

        // Idle timeout mid-record.
        wr_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        chk("to.err_before", 32'(load_error), 32'(1'b0));
        @(negedge clk);
        chk("to.err_at", 32'(load_error), 32'(1'b1));
        chk("to.start", 32'(start), 32'(1'b0));
        send_byte(8'h07);
        repeat (3) @(negedge clk);
        chk("to.stray_err", 32'(load_error), 32'(1'b1));
        chk("to.stray_start", 32'(start), 32'(1'b0));
        chk("to.nwr", 32'(wr_q.size()), 32'h0);
        tx_q = '{8'hA5, 8'h00, 8'h00};
        exp_wr.delete();
        run_tx(1, 1'b0);
        check_frame("to.recover", 1'b1, 1'b0, 8'd0);

        // Random frames against the frame-level model.
        for (int f = 0; f < 40; f++) begin
            tx_q.delete();
            exp_wr.delete();
            if ($urandom_range(0, 3) == 0) begin
                s = 8'($urandom_range(0, 255));
                tx_q.push_back((s == 8'hA5) ? 8'h00 : s);
            end
            n = 8'($urandom_range(0, 5));
            tx_q.push_back(8'hA5);
            tx_q.push_back(n);
            x = n;
            prev_a = 8'h00;
            for (int r = 0; r < int'(n); r++) begin
                a = 8'($urandom_range(0, 255));
                if (r > 0 && $urandom_range(0, 9) == 0) a = prev_a;
                prev_a = a;
                d = 24'($urandom);
                tx_q.push_back(a);
                tx_q.push_back(d[23:16]);
                tx_q.push_back(d[15:8]);
                tx_q.push_back(d[7:0]);
                exp_wr.push_back({a, d});
                x = x ^ a ^ d[23:16] ^ d[15:8] ^ d[7:0];
            end
            ok = ($urandom_range(0, 3) != 0);
            tx_q.push_back(ok ? x : (x ^ 8'($urandom_range(1, 255))));
            run_tx(3, 1'b1);
            check_frame($sformatf("rnd%0d", f), ok, !ok, n);
        end

        // Async reset between DH and DM.
        tx_q   = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'hCC, 8'hC9, 8'h03};
        exp_wr = '{32'h0007CCC9};
        run_tx(0, 1'b0);
        check_frame("pre_rst", 1'b1, 1'b0, 8'd1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h07);
        #2 clear = 1'b0;
        #1;
        chk("arst.ready", 32'(byte_ready), 32'(1'b0));
        chk("arst.addr", 32'(Code_address), 32'h0);
        chk("arst.data", 32'(Code_Data), 32'h0);
        chk("arst.wr", 32'(Write_Code), 32'(1'b0));
        chk("arst.start", 32'(start), 32'(1'b0));
        chk("arst.err", 32'(load_error), 32'(1'b0));
        chk("arst.records", 32'(records_written), 32'h0);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        #1;
        chk("arst.ready_before_clk", 32'(byte_ready), 32'(1'b0));
        wr_q.delete();
        send_byte(8'hCC);
        send_byte(8'hC9);
        send_byte(8'h03);
        repeat (4) @(negedge clk);
        chk("arst.nwr", 32'(wr_q.size()), 32'h0);
        chk("arst.start_after", 32'(start), 32'(1'b0));
        chk("arst.err_after", 32'(load_error), 32'(1'b0));
        chk("arst.records_after", 32'(records_written), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
